// File: rtl/lif_array_scheduler_if.sv
// Timestep request / spike address-event bundle between the sequencer,
// the LIF scheduler and the spike router.
interface lif_array_scheduler_if #(
    parameter int N_NEURONS = 8
) ();
    localparam int ID_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    logic                 step_start;
    logic [N_NEURONS-1:0] in_vec;
    logic                 busy;
    logic                 spk_valid;
    logic [ID_W-1:0]      spk_id;
    logic                 spk_ready;
    logic                 step_done;
    logic [N_NEURONS-1:0] spike_vec;

    // scheduler side: produces events and status
    modport master (
        input  step_start, in_vec, spk_ready,
        output busy, spk_valid, spk_id, step_done, spike_vec
    );

    // sequencer/router side
    modport slave (
        output step_start, in_vec, spk_ready,
        input  busy, spk_valid, spk_id, step_done, spike_vec
    );
endinterface

// File: rtl/lif_array_scheduler.sv
// One shared leaky integrate-and-fire datapath swept over N_NEURONS potentials,
// emitting each spike as an address-event in ascending id order.
module lif_array_scheduler #(
    parameter int N_NEURONS       = 8,
    parameter int P_WIDTH         = 8,
    parameter int THRESHOLD       = 10,
    parameter int LEAK_FACTOR_NUM = 9,
    parameter int LEAK_FACTOR_DEN = 10,
    parameter int IN_WEIGHT       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    lif_array_scheduler_if.master  bus
);
    localparam int IDX_W  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int PROD_W = P_WIDTH + $clog2(LEAK_FACTOR_NUM + 1) + 1;
    localparam int SUM_W  = PROD_W + 1;

    localparam logic [PROD_W-1:0]  NUM_C    = PROD_W'(LEAK_FACTOR_NUM);
    localparam logic [PROD_W-1:0]  DEN_C    = PROD_W'(LEAK_FACTOR_DEN);
    localparam logic [SUM_W-1:0]   WEIGHT_C = SUM_W'(IN_WEIGHT);
    localparam logic [SUM_W-1:0]   SAT_C    = SUM_W'((2 ** P_WIDTH) - 1);
    localparam logic [P_WIDTH-1:0] THRESH_C = P_WIDTH'(THRESHOLD);
    localparam logic [IDX_W-1:0]   LAST_C   = IDX_W'(N_NEURONS - 1);
    localparam logic [IDX_W-1:0]   ONE_C    = IDX_W'(1);

    typedef enum logic [1:0] {IDLE, UPDATE, EMIT, DONE} state_t;

    state_t               state_r;
    logic [IDX_W-1:0]     idx_r;
    logic [P_WIDTH-1:0]   pot_r [N_NEURONS];
    logic [N_NEURONS-1:0] in_lat_r;
    logic [N_NEURONS-1:0] work_r;
    logic                 busy_r;
    logic                 spk_valid_r;
    logic [IDX_W-1:0]     spk_id_r;
    logic                 step_done_r;
    logic [N_NEURONS-1:0] spike_vec_r;

    logic [P_WIDTH-1:0]   pot_cur_s;
    logic [PROD_W-1:0]    prod_s;
    logic [PROD_W-1:0]    leak_s;
    logic [SUM_W-1:0]     sum_s;
    logic [P_WIDTH-1:0]   cand_s;
    logic                 fire_s;
    logic                 last_s;

    // product is wide enough that the leak never wraps; only the final sum saturates
    assign pot_cur_s = pot_r[idx_r];
    assign prod_s    = {{(PROD_W-P_WIDTH){1'b0}}, pot_cur_s} * NUM_C;
    assign leak_s    = prod_s / DEN_C;
    assign sum_s     = {1'b0, leak_s} + (in_lat_r[idx_r] ? WEIGHT_C : {SUM_W{1'b0}});
    assign cand_s    = (sum_s > SAT_C) ? {P_WIDTH{1'b1}} : sum_s[P_WIDTH-1:0];
    assign fire_s    = (cand_s >= THRESH_C);
    assign last_s    = (idx_r == LAST_C);

    assign bus.busy      = busy_r;
    assign bus.spk_valid = spk_valid_r;
    assign bus.spk_id    = spk_id_r;
    assign bus.step_done = step_done_r;
    assign bus.spike_vec = spike_vec_r;

    // sweep controller, potential file and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= {IDX_W{1'b0}};
            in_lat_r    <= {N_NEURONS{1'b0}};
            work_r      <= {N_NEURONS{1'b0}};
            busy_r      <= 1'b0;
            spk_valid_r <= 1'b0;
            spk_id_r    <= {IDX_W{1'b0}};
            step_done_r <= 1'b0;
            spike_vec_r <= {N_NEURONS{1'b0}};
            for (int i = 0; i < N_NEURONS; i++) begin
                pot_r[i] <= {P_WIDTH{1'b0}};
            end
        end else begin
            step_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.step_start) begin
                        in_lat_r <= bus.in_vec;
                        idx_r    <= {IDX_W{1'b0}};
                        work_r   <= {N_NEURONS{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (fire_s) begin
                        pot_r[idx_r]  <= {P_WIDTH{1'b0}};
                        work_r[idx_r] <= 1'b1;
                        spk_id_r      <= idx_r;
                        spk_valid_r   <= 1'b1;
                        state_r       <= EMIT;
                    end else begin
                        pot_r[idx_r] <= cand_s;
                        if (last_s) begin
                            step_done_r <= 1'b1;
                            spike_vec_r <= work_r;
                            state_r     <= DONE;
                        end else begin
                            idx_r <= idx_r + ONE_C;
                        end
                    end
                end
                EMIT: begin
                    // spk_id stays put until the router takes the event
                    if (bus.spk_ready) begin
                        spk_valid_r <= 1'b0;
                        if (last_s) begin
                            step_done_r <= 1'b1;
                            spike_vec_r <= work_r;
                            state_r     <= DONE;
                        end else begin
                            idx_r   <= idx_r + ONE_C;
                            state_r <= UPDATE;
                        end
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r      <= 1'b0;
                    spk_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lif_array_scheduler.sv
// Directed bench for lif_array_scheduler: a default instance plus a
// saturating-parameter instance, both driven from the same stimulus.
module tb_lif_array_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_b = 1'b1;
    logic       step_start = 1'b0;
    logic [7:0] in_vec = 8'h00;
    logic       spk_ready = 1'b1;
    logic       sel_b = 1'b0;

    int         pass_cnt = 0;
    int         check_cnt = 0;
    int         step_cyc;
    bit         timed_out;
    logic [2:0] ev_q [$];

    always #5 clk = ~clk;

    lif_array_scheduler_if #(.N_NEURONS(8)) ifa ();
    lif_array_scheduler_if #(.N_NEURONS(8)) ifb ();

    assign ifa.step_start = step_start;
    assign ifa.in_vec     = in_vec;
    assign ifa.spk_ready  = spk_ready;
    assign ifb.step_start = step_start;
    assign ifb.in_vec     = in_vec;
    assign ifb.spk_ready  = spk_ready;

    lif_array_scheduler dut_a (.clk(clk), .rst(rst), .bus(ifa));

    lif_array_scheduler #(
        .N_NEURONS(8), .P_WIDTH(8), .THRESHOLD(255),
        .LEAK_FACTOR_NUM(1), .LEAK_FACTOR_DEN(1), .IN_WEIGHT(200)
    ) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    logic       m_valid, m_done, m_busy;
    logic [2:0] m_id;
    logic [7:0] m_vec;
    assign m_valid = sel_b ? ifb.spk_valid : ifa.spk_valid;
    assign m_done  = sel_b ? ifb.step_done : ifa.step_done;
    assign m_busy  = sel_b ? ifb.busy      : ifa.busy;
    assign m_id    = sel_b ? ifb.spk_id    : ifa.spk_id;
    assign m_vec   = sel_b ? ifb.spike_vec : ifa.spike_vec;

    // one sweep: step_done cycle lands at step_cyc == N+1 (+1 per single-cycle EMIT)
    task automatic run_step(input logic [7:0] vec);
        bit done_seen;
        @(negedge clk);
        in_vec = vec;
        step_start = 1'b1;
        @(posedge clk);
        #1 step_start = 1'b0;
        ev_q.delete();
        step_cyc = 0;
        timed_out = 1'b0;
        done_seen = 1'b0;
        while (!done_seen && !timed_out) begin
            @(negedge clk);
            step_cyc++;
            if (m_valid && spk_ready) ev_q.push_back(m_id);
            if (m_done) done_seen = 1'b1;
            else if (step_cyc > 100) timed_out = 1'b1;
        end
    endtask

    task automatic pulse_reset_a();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_cnt++;
        if (ifa.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", ifa.busy); else pass_cnt++;
        check_cnt++;
        if (ifa.spk_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ifa.spk_valid); else pass_cnt++;
        check_cnt++;
        if (ifa.step_done !== 1'b0) $display("FAIL reset_done: got %b want 0", ifa.step_done); else pass_cnt++;
        check_cnt++;
        if (ifa.spk_id !== 3'd0) $display("FAIL reset_id: got %0d want 0", ifa.spk_id); else pass_cnt++;
        check_cnt++;
        if (ifa.spike_vec !== 8'h00) $display("FAIL reset_spike_vec: got %h want 00", ifa.spike_vec); else pass_cnt++;
        check_cnt++;
        if (dut_a.pot_r[0] !== 8'd0) $display("FAIL reset_pot0: got %0d want 0", dut_a.pot_r[0]); else pass_cnt++;
    endtask

    task automatic test_integrate_fire();
        logic [7:0] want_pot [2];
        want_pot[0] = 8'd4;
        want_pot[1] = 8'd7;
        for (int s = 0; s < 2; s++) begin
            run_step(8'h01);
            check_cnt++;
            if (step_cyc !== 9 || ev_q.size() !== 0)
                $display("FAIL int_step%0d: got cyc=%0d ev=%0d want cyc=9 ev=0", s + 1, step_cyc, ev_q.size());
            else pass_cnt++;
            check_cnt++;
            if (dut_a.pot_r[0] !== want_pot[s])
                $display("FAIL int_pot_step%0d: got %0d want %0d", s + 1, dut_a.pot_r[0], want_pot[s]);
            else pass_cnt++;
        end
        run_step(8'h01);
        check_cnt++;
        if (step_cyc !== 10) $display("FAIL fire_latency: got %0d want 10", step_cyc); else pass_cnt++;
        check_cnt++;
        if (ev_q.size() !== 1 || ev_q[0] !== 3'd0)
            $display("FAIL fire_event: got n=%0d want one id 0", ev_q.size());
        else pass_cnt++;
        check_cnt++;
        if (ifa.spike_vec !== 8'h01) $display("FAIL fire_spike_vec: got %h want 01", ifa.spike_vec); else pass_cnt++;
        check_cnt++;
        if (dut_a.pot_r[0] !== 8'd0) $display("FAIL fire_pot0: got %0d want 0", dut_a.pot_r[0]); else pass_cnt++;
    endtask

    task automatic test_leak();
        logic [7:0] want_pot [3];
        want_pot[0] = 8'd6;
        want_pot[1] = 8'd5;
        want_pot[2] = 8'd4;
        run_step(8'h01);
        run_step(8'h01);
        check_cnt++;
        if (dut_a.pot_r[0] !== 8'd7) $display("FAIL leak_pre: got %0d want 7", dut_a.pot_r[0]); else pass_cnt++;
        for (int s = 0; s < 3; s++) begin
            run_step(8'h00);
            check_cnt++;
            if (step_cyc !== 9 || ev_q.size() !== 0 || dut_a.pot_r[0] !== want_pot[s])
                $display("FAIL leak_step%0d: got cyc=%0d ev=%0d pot=%0d want cyc=9 ev=0 pot=%0d",
                         s + 1, step_cyc, ev_q.size(), dut_a.pot_r[0], want_pot[s]);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        int         wait_cyc;
        int         stable_bad;
        bit         done_seen;
        logic [11:0] packed_ev;
        pulse_reset_a();
        run_step(8'hA5);
        run_step(8'hA5);
        spk_ready = 1'b0;
        @(negedge clk);
        in_vec = 8'hA5;
        step_start = 1'b1;
        @(posedge clk);
        #1 step_start = 1'b0;
        wait_cyc = 0;
        do begin
            @(negedge clk);
            wait_cyc++;
        end while (!ifa.spk_valid && wait_cyc < 20);
        stable_bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            if (ifa.spk_valid !== 1'b1 || ifa.spk_id !== 3'd0) stable_bad++;
        end
        check_cnt++;
        if (stable_bad !== 0) $display("FAIL stall_stable: got %0d bad cycles want 0", stable_bad); else pass_cnt++;
        spk_ready = 1'b1;
        ev_q.delete();
        done_seen = 1'b0;
        wait_cyc = 0;
        while (!done_seen && wait_cyc < 100) begin
            if (ifa.spk_valid && spk_ready) ev_q.push_back(ifa.spk_id);
            if (ifa.step_done) done_seen = 1'b1;
            else begin
                @(negedge clk);
                wait_cyc++;
            end
        end
        packed_ev = 12'h000;
        foreach (ev_q[i]) if (i < 4) packed_ev = packed_ev | (12'(ev_q[i]) << (3 * (3 - i)));
        check_cnt++;
        if (ev_q.size() !== 4 || packed_ev !== {3'd0, 3'd2, 3'd5, 3'd7})
            $display("FAIL stall_order: got n=%0d ids=%o want n=4 ids=0257", ev_q.size(), packed_ev);
        else pass_cnt++;
        check_cnt++;
        if (ifa.spike_vec !== 8'hA5) $display("FAIL stall_spike_vec: got %h want a5", ifa.spike_vec); else pass_cnt++;
    endtask

    task automatic test_ignore_start();
        int cyc;
        @(negedge clk);
        in_vec = 8'h00;
        step_start = 1'b1;
        @(posedge clk);
        #1 step_start = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) begin
                step_start = 1'b1;
                in_vec = 8'hFF;
            end else begin
                step_start = ifa.step_done;
            end
            if (ifa.step_done) break;
        end
        check_cnt++;
        if (cyc !== 9 || ifa.busy !== 1'b1)
            $display("FAIL ignore_done: got cyc=%0d busy=%b want cyc=9 busy=1", cyc, ifa.busy);
        else pass_cnt++;
        @(posedge clk);
        #1 step_start = 1'b0;
        in_vec = 8'h00;
        @(negedge clk);
        check_cnt++;
        if (ifa.busy !== 1'b0 || ifa.step_done !== 1'b0)
            $display("FAIL ignore_busy_fall: got busy=%b done=%b want 0 0", ifa.busy, ifa.step_done);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (ifa.busy !== 1'b0) $display("FAIL ignore_in_done: got busy=%b want 0", ifa.busy); else pass_cnt++;
        check_cnt++;
        if (dut_a.pot_r[1] !== 8'd0) $display("FAIL ignore_pot1: got %0d want 0", dut_a.pot_r[1]); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        run_step(8'h00);
        run_step(8'h00);
        check_cnt++;
        if (step_cyc !== 9 || ev_q.size() !== 0)
            $display("FAIL b2b_first_idle: got cyc=%0d ev=%0d want cyc=9 ev=0", step_cyc, ev_q.size());
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        sel_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        run_step(8'h01);
        check_cnt++;
        if (step_cyc !== 9 || dut_b.pot_r[0] !== 8'd200)
            $display("FAIL sat_step1: got cyc=%0d pot=%0d want cyc=9 pot=200", step_cyc, dut_b.pot_r[0]);
        else pass_cnt++;
        run_step(8'h01);
        check_cnt++;
        if (ev_q.size() !== 1 || ev_q[0] !== 3'd0 || m_vec !== 8'h01)
            $display("FAIL sat_spike: got n=%0d vec=%h want one id 0 vec=01", ev_q.size(), m_vec);
        else pass_cnt++;
        check_cnt++;
        if (dut_b.pot_r[0] !== 8'd0) $display("FAIL sat_pot0: got %0d want 0", dut_b.pot_r[0]); else pass_cnt++;
        sel_b = 1'b0;
    endtask

    task automatic test_reset_mid_emit();
        int  wait_cyc;
        bit  done_seen;
        pulse_reset_a();
        run_step(8'h01);
        run_step(8'h01);
        spk_ready = 1'b0;
        @(negedge clk);
        in_vec = 8'h01;
        step_start = 1'b1;
        @(posedge clk);
        #1 step_start = 1'b0;
        wait_cyc = 0;
        do begin
            @(negedge clk);
            wait_cyc++;
        end while (!ifa.spk_valid && wait_cyc < 20);
        check_cnt++;
        if (ifa.spk_valid !== 1'b1) $display("FAIL rst_emit_reach: got valid=%b want 1", ifa.spk_valid); else pass_cnt++;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        spk_ready = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (ifa.spk_valid !== 1'b0 || ifa.busy !== 1'b0)
            $display("FAIL rst_emit_abort: got valid=%b busy=%b want 0 0", ifa.spk_valid, ifa.busy);
        else pass_cnt++;
        done_seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (ifa.step_done) done_seen = 1'b1;
            @(negedge clk);
        end
        check_cnt++;
        if (done_seen !== 1'b0) $display("FAIL rst_emit_no_done: got step_done seen=%b want 0", done_seen); else pass_cnt++;
        run_step(8'h01);
        check_cnt++;
        if (dut_a.pot_r[0] !== 8'd4 || ev_q.size() !== 0)
            $display("FAIL rst_emit_cleared: got pot=%0d ev=%0d want pot=4 ev=0", dut_a.pot_r[0], ev_q.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_integrate_fire();
        test_leak();
        test_stall();
        test_ignore_start();
        test_back_to_back();
        test_saturate();
        test_reset_mid_emit();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule

// File: doc/lif_array_scheduler.md
Name: lif_array_scheduler

Overview:
- Time-multiplexed controller that shares one leaky integrate-and-fire update datapath across N_NEURONS neurons.
- Membrane potentials are held in an internal register file. On each timestep request the block sweeps neurons 0..N-1, one update per cycle.
- Each spike is emitted as an address-event (neuron id) over a valid/ready handshake. A done pulse and a per-step spike vector follow the sweep.
- It sits between the network timestep sequencer and the spike router.

Parameters:
- N_NEURONS, 8, number of neurons served (≥2).
- P_WIDTH, 8, membrane potential width, unsigned.
- THRESHOLD, 10, firing threshold θ (< 2^P_WIDTH).
- LEAK_FACTOR_NUM, 9, leak numerator λ.
- LEAK_FACTOR_DEN, 10, leak denominator (≥1, NUM ≤ DEN).
- IN_WEIGHT, 4, potential added when a neuron's input bit is 1.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- step_start  in  1  pulse requesting one timestep sweep; honoured only in IDLE.
- in_vec  in  N_NEURONS  binary inputs; bit k belongs to neuron k; sampled only in the cycle step_start is accepted.
- busy  out  1  high from the cycle after acceptance through the DONE cycle.
- spk_valid  out  1  spike event present.
- spk_id  out  $clog2(N_NEURONS)  id of spiking neuron; stable while spk_valid && !spk_ready.
- spk_ready  in  1  downstream accepts the event.
- step_done  out  1  one-cycle pulse at end of sweep.
- spike_vec  out  N_NEURONS  spikes of the most recent completed step; bit k = neuron k fired.

Behaviour:
- Reset:
  - All potentials clear to 0. FSM goes to IDLE. Index clears to 0.
  - busy, spk_valid, step_done, spk_id and spike_vec all clear to 0.
  - A reset mid-sweep or mid-emit aborts the step. No step_done is produced and the pending event is dropped.
- FSM states: IDLE, UPDATE, EMIT, DONE.
- IDLE:
  - step_start=1 latches in_vec into an internal register, sets index=0, clears the working spike vector, and moves to UPDATE.
  - step_start while not in IDLE is ignored; no queuing.
- UPDATE (neuron k=index, one cycle):
  - cand = floor(P[k]*LEAK_FACTOR_NUM / LEAK_FACTOR_DEN) + (in_lat[k] ? IN_WEIGHT : 0).
  - The intermediate product uses P_WIDTH+$clog2(LEAK_FACTOR_NUM+1)+1 bits, so it never overflows.
  - cand saturates at 2^P_WIDTH-1.
  - If cand ≥ THRESHOLD: P[k]←0, set working bit k, load spk_id=k, assert spk_valid, go to EMIT.
  - Else: P[k]←cand. If k==N-1 go to DONE, else index←k+1 and stay in UPDATE.
- EMIT:
  - spk_valid held with spk_id stable until the cycle spk_ready=1.
  - On the handshake cycle: drop spk_valid next cycle; index←k+1 and back to UPDATE, or to DONE if k==N-1.
  - spk_ready outside EMIT has no effect.
- DONE (one cycle): step_done=1, spike_vec←working vector, then IDLE.
  - busy drops the cycle after DONE.
  - A step_start coinciding with the DONE cycle is ignored.
  - A step_start in the first IDLE cycle is accepted.
- Latency:
  - With no spikes, acceptance at cycle t gives UPDATE at t+1..t+N and step_done at t+N+1.
  - Each spike adds at least one EMIT cycle; with spk_ready tied high, exactly one per spike.
- Ordering: events are always emitted in ascending id order, at most one per neuron per step.
- Potentials persist across steps. Neurons are not updated outside a sweep; no leak is applied in IDLE.

Test Plan:
- Defaults (N=8, θ=10, 9/10, W=4), spk_ready=1, in_vec=0x01 for steps 1..3:
  - P[0] goes 4, 7, then cand=10 → spike on step 3.
  - Event id=0 emitted; step_done at t+10 (8 UPDATE + 1 EMIT + 1).
  - spike_vec=0x01 and P[0]=0 afterwards.
- in_vec=0x00 after P[0]=7: P[0] goes 6, 5, 4 over three steps.
  - No events; step_done exactly N+1 cycles after each start.
- Three steps with in_vec=0xA5, then spk_ready held low 5 cycles at the first event:
  - Events on the third step are ids 0, 2, 5, 7 in order.
  - spk_valid and spk_id=0 stay stable for the 5 stalled cycles.
  - spike_vec=0xA5.
- step_start pulsed during UPDATE and again in the DONE cycle: both are ignored; busy falls 1 cycle after step_done.
- Override LEAK_FACTOR_NUM=DEN=1, THRESHOLD=255, IN_WEIGHT=200, in_vec bit0=1:
  - Step 1: P[0]=200. Step 2: cand saturates to 255 ≥ θ → spike, P[0]=0.
- rst asserted mid-EMIT:
  - Next cycle spk_valid=0, busy=0, no step_done.
  - A following step with in_vec=0x01 gives P[0]=4, confirming potentials were cleared.
